seven_seg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver. It replaces the fixed 4-digit display path in the lab top level. It scans `NUM_DIGITS` common-anode digits at a programmable refresh rate and decodes 4-bit hex per digit. It supports per-digit enable, decimal points and optional leading-zero blanking. New display data is double-buffered so that a digit value never changes mid-frame.

---
 rtl/seven_seg_scan_driver.sv | 203 ++++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Multiplexed common-anode seven-segment driver. It scans NUM_DIGITS digits,
// one slot of REFRESH_DIV clock cycles per digit, and decodes one hex nibble
// per digit. Per-digit enables, decimal points and optional leading-zero
// blanking are supported.
//
// New display data is double-buffered. A load goes into a pending buffer, and
// the pending buffer is copied to the active buffer only at a frame boundary.
// This means a digit never changes value in the middle of a frame.
//
// Ports
//   clk          in   system clock; all logic runs on its rising edge
//   reset        in   asynchronous, active-low reset
//   data_in      in   4*NUM_DIGITS hex nibbles; nibble i -> digit i (0 = right)
//   dp_in        in   NUM_DIGITS decimal-point requests, 1 = lit
//   digit_en     in   NUM_DIGITS digit enables, 1 = digit may light
//   load         in   capture request for data_in / dp_in / digit_en
//   pending      out  captured data is waiting for the next frame boundary
//   frame_start  out  one-cycle pulse with the first cycle of each frame
//   segs         out  segment drive, active-low, bit 0 = CA .. bit 6 = CG
//   dp           out  decimal-point drive, active-low
//   an           out  anode enables, active-low, bit i = digit i
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_start,
    output logic [6:0]              segs,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

    // Active-low segment pattern for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Scan timing.
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tick, wrap;

    // Pending and active buffers.
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;

    // Registered outputs.
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            segs_q, segs_d;
    logic                  dp_q, dp_d;
    logic                  frame_start_q, frame_start_d;

    // Decode helpers.
    logic [NUM_DIGITS-1:0] lead_blank;
    logic                  zero_run;
    logic                  digit_blank;
    logic [3:0]            cur_nib;

    // NOTE: every variable that is written in always_comb is given a default
    // first. A path that leaves a variable unassigned would infer a latch.
    always_comb begin
        tick = (pcnt_q == PCNT_MAX);
        wrap = tick && (idx_q == IDX_MAX);

        pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
        idx_d  = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end

        // The last load wins. A load that lands on a boundary stays pending,
        // because the boundary consumes the old pending contents.
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_en_d   = pend_en_q;
        pending_d   = pending_q;
        if (wrap) begin
            pending_d = 1'b0;
        end
        if (load) begin
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            pend_en_d   = digit_en;
            pending_d   = 1'b1;
        end

        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;
        if (wrap && pending_q) begin
            act_data_d = pend_data_q;
            act_dp_d   = pend_dp_q;
            act_en_d   = pend_en_q;
        end

        // A digit is leading-blanked when it and every digit above it are
        // zero. Digit 0 is always shown, so that a value of 0 still displays.
        zero_run   = 1'b1;
        lead_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (act_data_d[i*4 +: 4] == 4'h0);
            lead_blank[i] = (BLANK_LEADING != 0) && (i != 0) && zero_run;
        end

        // The outputs are decoded from next-state values. The registered
        // drive therefore follows idx and the active buffer by exactly one
        // edge, with no extra pipeline slip.
        cur_nib     = act_data_d[int'(idx_d)*4 +: 4];
        digit_blank = !act_en_d[idx_d] || lead_blank[idx_d];

        an_d   = '1;
        segs_d = 7'h7F;
        dp_d   = 1'b1;
        if (!digit_blank) begin
            an_d[idx_d] = 1'b0;
            segs_d      = hex7(cur_nib);
            dp_d        = !act_dp_d[idx_d];
        end

        frame_start_d = wrap;
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    // Every flop then samples pre-edge values, whatever the statement order.
    // NOTE: the display buffers are reset along with the control state. This
    // way a reset always leaves a known, fully enabled all-zero display.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q        <= '0;
            idx_q         <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_en_q     <= '1;
            pending_q     <= 1'b0;
            act_data_q    <= '0;
            act_dp_q      <= '0;
            act_en_q      <= '1;
            an_q          <= '1;
            segs_q        <= 7'h7F;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            pcnt_q        <= pcnt_d;
            idx_q         <= idx_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_en_q     <= pend_en_d;
            pending_q     <= pending_d;
            act_data_q    <= act_data_d;
            act_dp_q      <= act_dp_d;
            act_en_q      <= act_en_d;
            an_q          <= an_d;
            segs_q        <= segs_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pending     = pending_q;
    assign frame_start = frame_start_q;
    assign segs        = segs_q;
    assign dp          = dp_q;
    assign an          = an_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//
// Directed bench for seven_seg_scan_driver with NUM_DIGITS = 4 and
// REFRESH_DIV = 4. Two instances share the same stimulus:
//   dut_bl  BLANK_LEADING = 1
//   dut_nb  BLANK_LEADING = 0
// Expected frames are written out by hand as per-slot tables.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    localparam int N  = 4;
    localparam int RD = 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        load     = 1'b0;
    logic [15:0] data_in  = 16'h0;
    logic [3:0]  dp_in    = 4'h0;
    logic [3:0]  digit_en = 4'hF;

    logic       pend_a, fs_a, dp_a;
    logic [6:0] segs_a;
    logic [3:0] an_a;
    logic       pend_b, fs_b, dp_b;
    logic [6:0] segs_b;
    logic [3:0] an_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] cap_a [16];
    logic [11:0] cap_b [16];
    logic [15:0] fs_cap;

    seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_LEADING(1)) dut_bl (
        .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in),
        .digit_en(digit_en), .load(load), .pending(pend_a), .frame_start(fs_a),
        .segs(segs_a), .dp(dp_a), .an(an_a)
    );

    seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in),
        .digit_en(digit_en), .load(load), .pending(pend_b), .frame_start(fs_b),
        .segs(segs_b), .dp(dp_b), .an(an_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dpv);
        data_in  = d;
        digit_en = en;
        dp_in    = dpv;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    // Stop on the first cycle of the next frame (bounded to 40 cycles).
    task automatic wait_fs(input string tag, input logic exp_pend);
        int k = 0;
        while (fs_a !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        check({tag, "_fs_a"}, fs_a, 1);
        check({tag, "_fs_b"}, fs_b, 1);
        check({tag, "_pend_a"}, pend_a, exp_pend);
        check({tag, "_pend_b"}, pend_b, exp_pend);
    endtask

    task automatic capture();
        for (int i = 0; i < 16; i++) begin
            cap_a[i]  = {an_a, segs_a, dp_a};
            cap_b[i]  = {an_b, segs_b, dp_b};
            fs_cap[i] = fs_a;
            step();
        end
    endtask

    // Expected tables are packed with slot 3 in the MSBs.
    task automatic check_frame(input string tag, input bit use_b, input logic [15:0] an_e,
                               input logic [27:0] segs_e, input logic [3:0] dp_e);
        for (int i = 0; i < 16; i++) begin
            int s;
            logic [11:0] exp_w;
            s     = i / 4;
            exp_w = {an_e[s*4 +: 4], segs_e[s*7 +: 7], dp_e[s]};
            check($sformatf("%s_c%0d", tag, i), use_b ? cap_b[i] : cap_a[i], exp_w);
        end
    endtask

    initial begin
        // 1. Reset and scan.
        #2 reset = 1'b0;
        repeat (5) step();
        check("rst_an", an_a, 4'hF);
        check("rst_segs", segs_a, 7'h7F);
        check("rst_dp", dp_a, 1'b1);
        check("rst_pend", pend_a, 1'b0);
        check("rst_fs", fs_a, 1'b0);
        check("rst_an_nb", an_b, 4'hF);
        reset = 1'b1;
        step();
        check("first_bl", {an_a, segs_a, dp_a}, {4'hE, 7'h40, 1'b1});
        check("first_nb", {an_b, segs_b, dp_b}, {4'hE, 7'h40, 1'b1});
        wait_fs("t1", 1'b0);
        capture();
        check("t1_fs_pattern", fs_cap, 16'h0001);
        check("t1_fs_next", fs_a, 1'b1);
        check_frame("t1_nb", 1'b1, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);
        check_frame("t1_bl", 1'b0, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);

        // 2. Load and decode.
        do_load(16'h12AF, 4'hF, 4'h0);
        check("t2_pend_set", pend_a, 1'b1);
        wait_fs("t2", 1'b0);
        capture();
        check_frame("t2_bl", 1'b0, 16'h7BDE, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF);
        check_frame("t2_nb", 1'b1, 16'h7BDE, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF);

        // 3. Leading-zero blanking.
        do_load(16'h0050, 4'hF, 4'h0);
        check("t3_pend_set", pend_a, 1'b1);
        wait_fs("t3", 1'b0);
        capture();
        check_frame("t3_bl", 1'b0, 16'hFFDE, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF);
        check_frame("t3_nb", 1'b1, 16'h7BDE, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF);

        // 4. Enables and decimal points.
        do_load(16'h8888, 4'b0101, 4'b0011);
        wait_fs("t4", 1'b0);
        capture();
        check_frame("t4_bl", 1'b0, 16'hFBFE, {7'h7F, 7'h00, 7'h7F, 7'h00}, 4'hE);
        check_frame("t4_nb", 1'b1, 16'hFBFE, {7'h7F, 7'h00, 7'h7F, 7'h00}, 4'hE);

        // 5. Double-buffer rules, starting on the first cycle of a frame.
        check("t5_at_fs", fs_a, 1'b1);
        do_load(16'h1111, 4'hF, 4'h0);
        do_load(16'h2222, 4'hF, 4'h0);
        repeat (13) step();
        // This is the last cycle of the frame, i.e. the boundary cycle.
        do_load(16'h3333, 4'hF, 4'h0);
        check("t5_fs_f1", fs_a, 1'b1);
        check("t5_pend_stays", pend_a, 1'b1);
        capture();
        check_frame("t5_f1", 1'b0, 16'h7BDE, {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);
        check("t5_fs_f2", fs_a, 1'b1);
        check("t5_pend_f2", pend_a, 1'b0);
        capture();
        check_frame("t5_f2", 1'b0, 16'h7BDE, {7'h30, 7'h30, 7'h30, 7'h30}, 4'hF);

        // 6. Reset mid-frame, with a load still pending.
        do_load(16'h4444, 4'hF, 4'hF);
        repeat (7) step();
        check("t6_slot2", an_a, 4'b1011);
        #2 reset = 1'b0;
        #1;
        check("t6_an", an_a, 4'hF);
        check("t6_segs", segs_a, 7'h7F);
        check("t6_dp", dp_a, 1'b1);
        check("t6_pend", pend_a, 1'b0);
        check("t6_fs", fs_a, 1'b0);
        repeat (5) step();
        reset = 1'b1;
        step();
        check("t6_first_bl", {an_a, segs_a, dp_a}, {4'hE, 7'h40, 1'b1});
        check("t6_first_nb", {an_b, segs_b, dp_b}, {4'hE, 7'h40, 1'b1});
        wait_fs("t6", 1'b0);
        capture();
        check_frame("t6_bl", 1'b0, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
        check_frame("t6_nb", 1'b1, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
